pipe_chain: RTL and testbench
=============================

# pipe_chain

Parametrised elastic pipeline-register chain for the processor datapath. It generalises the fixed inter-stage registers into a `STAGES`-deep chain with per-stage valid bits, hazard hold requests, selective flush and a ready/valid handshake at both ends. Bubbles collapse: a stalled stage only back-pressures upstream stages that hold valid data. Hazard and branch units drive `hold` and `flush`; the datapath taps every stage through `stage_data` and `stage_valid`.

## Interface
- `STAGES`, 3, number of register stages (≥1); stage 0 is youngest, stage `STAGES-1` drives the output.
- `DATA_W`, 32, payload width per stage.
- `RESET_VAL`, 0, payload value of every stage after reset.

Ports:
- `clk` in 1: clock. One clock; all state on rising edge.
- `arst` in 1: reset, asynchronous, active-high.
- `enable` in 1: global advance enable.
- `in_valid` in 1: upstream item present.
- `in_data` in `DATA_W`: upstream payload.
- `in_ready` out 1: stage 0 accepts this cycle.
- `hold` in `STAGES`: bit i set = stage i must not advance (hazard stall).
- `flush` in `STAGES`: bit i set = stage i is invalid next cycle.
- `out_valid` out 1: stage `STAGES-1` offers an item.
- `out_ready` in 1: downstream accepts.
- `out_data` out `DATA_W`: payload of stage `STAGES-1`.
- `stage_valid` out `STAGES`: valid bit per stage.
- `stage_data` out `STAGES*DATA_W`: stage i at `[i*DATA_W +: DATA_W]`.
- `stall_cnt` out 32: input-stall cycle counter (see Configuration).
- `flush_cnt` out 32: effective-flush counter (see Configuration).

## Operation
- Blocking is combinational and computed from current state:
  - `blocked[S-1] = v[S-1] & (hold[S-1] | ~out_ready)`.
  - `blocked[i] = v[i] & (hold[i] | blocked[i+1])`.
- `move[i] = v[i] & ~blocked[i]`.
- `in_ready = enable & ~blocked[0]`.
- `out_valid = enable & v[S-1] & ~hold[S-1]`.
- An invalid stage never blocks, so bubbles are absorbed.
- Next state when `enable=1`, per stage i (priority order):
  - `flush[i]`: `v[i]<=0`. Any item that would have entered stage i is discarded. Payload is unchanged.
  - else `blocked[i]`: stage i holds `v` and data.
  - else `v[i] <= src_move`, where `src_move` is `in_valid` for i=0 and `move[i-1]` otherwise. Data loads from the source only when `src_move=1`; otherwise data is retained.
- Flush does not alter `blocked` in the same cycle. A blocked stage that is flushed still stalls upstream for that cycle.
- To flush all younger work, the caller sets several bits; the block applies them independently.
- `enable=0`: all state frozen, flush and hold ignored, `in_ready=0`, `out_valid=0`.
- `out_data` and `stage_data` always show register contents, valid or not.

## Timing
- Reset (async, immediate): all `v=0`, all payloads=`RESET_VAL`, counters=0. Outputs are `in_ready=enable`, `out_valid=0`, `out_data=RESET_VAL`.
- Latency from input to output is `STAGES` cycles with no hold or back-pressure. Throughput is 1 item/cycle.
- An item accepted at edge k appears in stage i after edge k+i (unstalled).
- There is a combinational path `out_ready`/`hold` → `in_ready`, with depth O(`STAGES`).
- Reset asserted mid-operation discards all items. The first accept after release occurs on the first edge with `in_valid & in_ready`.

## Configuration
- `PIPE_CHAIN_PERF_EN` defined:
  - `stall_cnt` increments each cycle with `enable & in_valid & ~in_ready`.
  - `flush_cnt` increments each cycle with `enable & |(flush & v)`.
  - Both saturate at 0xFFFFFFFF and reset to 0.
- Not defined: counters are not built, and `stall_cnt`/`flush_cnt` are tied to 0. Port list is identical either way.

## Test plan
- STAGES=3, `out_ready=1`, stream 0x11,0x22,0x33 on consecutive cycles → `out_data` 0x11,0x22,0x33 on cycles 3,4,5 with `out_valid=1`; `in_ready` stays 1.
- `out_ready=0` with 3 items loaded → `in_ready=0`, contents frozen. Raise `out_ready` → items drain in order, one per cycle, none lost or duplicated.
- Stages {2:0xA, 1:empty, 0:0xB}, `out_ready=0`, `in_valid` with 0xC → next cycle stage 1 = 0xB, stage 0 = 0xC (bubble collapsed). After that, `in_ready=0`.
- `hold[1]=1` for 2 cycles with stages full and `out_ready=1` → stage 2 drains and becomes invalid. Stages 0–1 keep their data, `in_ready=0`, and `stall_cnt=2` under `PIPE_CHAIN_PERF_EN`.
- `flush=3'b011` while stage 0 receives 0x55 and stage 1 is valid → next cycle `stage_valid[1:0]=0`, 0x55 dropped, stage 2 advances normally. `flush_cnt=1`.
- Assert `arst` mid-stream → `stage_valid=0`, all payloads `RESET_VAL` immediately without waiting for a clock edge. `enable=0` freezes state and forces `in_ready=0`, `out_valid=0`.

Source files
------------

// File: rtl/pipe_chain.sv
// Elastic pipeline-register chain with per-stage valid, hold, flush and ready/valid ends.
// Define PIPE_CHAIN_PERF_EN to build the saturating stall/flush performance counters.
module pipe_chain #(
    parameter int                STAGES    = 3,
    parameter int                DATA_W    = 32,
    parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
    input  logic                     clk,
    input  logic                     arst,
    input  logic                     enable,
    input  logic                     in_valid,
    input  logic [DATA_W-1:0]        in_data,
    output logic                     in_ready,
    input  logic [STAGES-1:0]        hold,
    input  logic [STAGES-1:0]        flush,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DATA_W-1:0]        out_data,
    output logic [STAGES-1:0]        stage_valid,
    output logic [STAGES*DATA_W-1:0] stage_data,
    output logic [31:0]              stall_cnt,
    output logic [31:0]              flush_cnt
);

    logic [STAGES-1:0] vld_q;
    logic [STAGES-1:0] blocked;
    logic [DATA_W-1:0] data_q [STAGES];

    // Back-pressure ripples from the output toward stage 0; empty stages never block.
    always_comb begin
        logic downstream;
        downstream = ~out_ready;
        for (int i = STAGES - 1; i >= 0; i--) begin
            blocked[i] = vld_q[i] & (hold[i] | downstream);
            downstream = blocked[i];
        end
    end

    for (genvar g = 0; g < STAGES; g++) begin : g_stage
        logic              src_v;
        logic [DATA_W-1:0] src_d;
        logic              vld_p;
        logic [DATA_W-1:0] data_p;

        if (g == 0) begin : g_head
            assign src_v = in_valid;
            assign src_d = in_data;
        end else begin : g_body
            assign src_v = vld_q[g-1] & ~blocked[g-1];
            assign src_d = data_q[g-1];
        end

        // Stage register: flush wins over hold, payload only moves with a valid item.
        always_ff @(posedge clk or posedge arst) begin
            if (arst) begin
                vld_p  <= 1'b0;
                data_p <= RESET_VAL;
            end else if (enable) begin
                if (flush[g]) begin
                    vld_p <= 1'b0;
                end else if (!blocked[g]) begin
                    vld_p <= src_v;
                    if (src_v) begin
                        data_p <= src_d;
                    end
                end
            end
        end

        assign vld_q[g]                         = vld_p;
        assign data_q[g]                        = data_p;
        assign stage_data[g*DATA_W +: DATA_W]   = data_p;
    end

    assign stage_valid = vld_q;
    assign in_ready    = enable & ~blocked[0];
    assign out_valid   = enable & vld_q[STAGES-1] & ~hold[STAGES-1];
    assign out_data    = data_q[STAGES-1];

`ifdef PIPE_CHAIN_PERF_EN
    function automatic logic [31:0] sat_inc(input logic [31:0] cnt);
        return (&cnt) ? cnt : cnt + 32'd1;
    endfunction

    logic [31:0] stall_q;
    logic [31:0] flush_q;

    // Flushes count only when they actually kill a valid item.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            if (enable & in_valid & ~in_ready) begin
                stall_q <= sat_inc(stall_q);
            end
            if (enable & (|(flush & vld_q))) begin
                flush_q <= sat_inc(flush_q);
            end
        end
    end

    assign stall_cnt = stall_q;
    assign flush_cnt = flush_q;
`else
    assign stall_cnt = '0;
    assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_chain.sv
// Directed bench for pipe_chain: streaming, back-pressure, bubble collapse, hold, flush, reset, enable.
module tb_pipe_chain;
    localparam int          STAGES = 3;
    localparam int          DATA_W = 32;
    localparam logic [31:0] RV     = 32'h0BAD_F00D;
`ifdef PIPE_CHAIN_PERF_EN
    localparam logic [31:0] PERF   = 32'd1;
`else
    localparam logic [31:0] PERF   = 32'd0;
`endif

    logic                     clk;
    logic                     arst;
    logic                     enable;
    logic                     in_valid;
    logic [DATA_W-1:0]        in_data;
    logic                     in_ready;
    logic [STAGES-1:0]        hold;
    logic [STAGES-1:0]        flush;
    logic                     out_valid;
    logic                     out_ready;
    logic [DATA_W-1:0]        out_data;
    logic [STAGES-1:0]        stage_valid;
    logic [STAGES*DATA_W-1:0] stage_data;
    logic [31:0]              stall_cnt;
    logic [31:0]              flush_cnt;

    int n_cmp = 0;
    int n_err = 0;

    pipe_chain #(.STAGES(STAGES), .DATA_W(DATA_W), .RESET_VAL(RV)) dut (
        .clk(clk), .arst(arst), .enable(enable),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .hold(hold), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .stage_valid(stage_valid), .stage_data(stage_data),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        arst = 1'b1; enable = 1'b1; in_valid = 1'b0; in_data = '0;
        hold = '0; flush = '0; out_ready = 1'b1;
        #3;
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_out_data", out_data, RV);
        chk("rst_stage_valid", stage_valid, 3'b000);
        chk("rst_stage_data", stage_data, {RV, RV, RV});
        chk("rst_stall_cnt", stall_cnt, 32'd0);
        chk("rst_flush_cnt", flush_cnt, 32'd0);
        tick();
        arst = 1'b0;

        // streaming, latency 3
        in_valid = 1'b1; in_data = 32'h11; settle();
        chk("s_in_ready0", in_ready, 1'b1);
        tick(); in_data = 32'h22; settle();
        chk("s_in_ready1", in_ready, 1'b1);
        tick(); in_data = 32'h33; settle();
        chk("s_in_ready2", in_ready, 1'b1);
        tick(); in_valid = 1'b0; settle();
        chk("s_out_valid0", out_valid, 1'b1);
        chk("s_out_data0", out_data, 32'h11);
        tick();
        chk("s_out_data1", out_data, 32'h22);
        chk("s_out_valid1", out_valid, 1'b1);
        tick();
        chk("s_out_data2", out_data, 32'h33);
        tick();
        chk("s_drained", out_valid, 1'b0);
        chk("s_data_kept", out_data, 32'h33);

        // back-pressure
        out_ready = 1'b0; in_valid = 1'b1;
        in_data = 32'hA1; tick();
        in_data = 32'hA2; tick();
        in_data = 32'hA3; tick();
        in_data = 32'hA4; settle();
        chk("bp_in_ready", in_ready, 1'b0);
        chk("bp_out_valid", out_valid, 1'b1);
        tick();
        chk("bp_frozen", stage_data, {32'hA1, 32'hA2, 32'hA3});
        chk("bp_valid", stage_valid, 3'b111);
        in_valid = 1'b0; out_ready = 1'b1; settle();
        chk("bp_out0", out_data, 32'hA1);
        tick();
        chk("bp_out1", out_data, 32'hA2);
        tick();
        chk("bp_out2", out_data, 32'hA3);
        tick();
        chk("bp_empty", out_valid, 1'b0);

        // bubble collapse
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 32'hA; tick();
        in_valid = 1'b0; tick();
        in_valid = 1'b1; in_data = 32'hB; tick();
        chk("bc_pattern", stage_valid, 3'b101);
        in_data = 32'hC; settle();
        chk("bc_in_ready", in_ready, 1'b1);
        tick();
        chk("bc_valid", stage_valid, 3'b111);
        chk("bc_data", stage_data, {32'hA, 32'hB, 32'hC});
        chk("bc_in_ready_after", in_ready, 1'b0);
        in_valid = 1'b0; out_ready = 1'b1;
        tick(); tick(); tick();
        chk("bc_drained", stage_valid, 3'b000);
        chk("bc_stall_cnt", stall_cnt, PERF);

        #1; arst = 1'b1; settle(); arst = 1'b0;
        chk("rst2_stall_cnt", stall_cnt, 32'd0);

        // hold on stage 1
        in_valid = 1'b1;
        in_data = 32'hD1; tick();
        in_data = 32'hD2; tick();
        in_data = 32'hD3; tick();
        in_data = 32'hD4; hold = 3'b010; settle();
        chk("h_in_ready", in_ready, 1'b0);
        tick();
        chk("h_valid0", stage_valid, 3'b011);
        tick();
        chk("h_valid1", stage_valid, 3'b011);
        chk("h_data", stage_data[63:0], {32'hD2, 32'hD3});
        chk("h_in_ready2", in_ready, 1'b0);
        chk("h_out_valid", out_valid, 1'b0);
        chk("h_stall_cnt", stall_cnt, 32'd2 * PERF);
        hold = '0; in_valid = 1'b0; tick();
        chk("h_release", out_data, 32'hD2);
        chk("h_release_v", out_valid, 1'b1);
        tick(); tick();
        chk("h_drained", stage_valid, 3'b000);

        // selective flush
        in_valid = 1'b1;
        in_data = 32'hE1; tick();
        in_data = 32'hE2; tick();
        in_data = 32'h55; flush = 3'b011; settle();
        chk("f_in_ready", in_ready, 1'b1);
        tick();
        flush = '0; in_valid = 1'b0; settle();
        chk("f_valid", stage_valid, 3'b100);
        chk("f_out_data", out_data, 32'hE1);
        chk("f_s0_data", stage_data[31:0], 32'hE2);
        chk("f_flush_cnt", flush_cnt, PERF);
        chk("f_stall_cnt", stall_cnt, 32'd2 * PERF);
        tick();
        chk("f_drained", stage_valid, 3'b000);

        // asynchronous reset mid-stream
        in_valid = 1'b1;
        in_data = 32'hF1; tick();
        in_data = 32'hF2; tick();
        #2; arst = 1'b1; #1;
        chk("ar_valid", stage_valid, 3'b000);
        chk("ar_data", stage_data, {RV, RV, RV});
        chk("ar_out_data", out_data, RV);
        chk("ar_flush_cnt", flush_cnt, 32'd0);
        chk("ar_in_ready", in_ready, 1'b1);
        arst = 1'b0;

        // enable low freezes everything
        in_data = 32'hF1; tick();
        in_data = 32'hF2; tick();
        enable = 1'b0; in_data = 32'hF3; flush = 3'b111; hold = 3'b111; settle();
        chk("en_in_ready", in_ready, 1'b0);
        chk("en_out_valid", out_valid, 1'b0);
        tick(); tick();
        chk("en_valid", stage_valid, 3'b011);
        chk("en_data", stage_data[63:0], {32'hF1, 32'hF2});
        chk("en_flush_cnt", flush_cnt, 32'd0);
        chk("en_stall_cnt", stall_cnt, 32'd0);
        enable = 1'b1; flush = '0; hold = '0; in_valid = 1'b0; settle();
        chk("en_resume", in_ready, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
